// File: rtl/crc32_fifo_reader.sv
// Bit-serial reflected CRC-32 engine that drains a first-word-fall-through byte FIFO.
// One byte is folded per 8 clocks; the next pop overlaps the last bit, so there are no bubble cycles.
module crc32_fifo_reader #(
  parameter logic [31:0] POLY  = 32'hEDB88320,
  parameter int          CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             init,
  input  logic [7:0]       fifo_dout,
  input  logic             fifo_empty,
  output logic             fifo_done,
  output logic [31:0]      crc_out,
  output logic [CNT_W-1:0] byte_count,
  output logic             busy,
  output logic             idle
);

  typedef enum logic {
    IDLE,
    SHIFT
  } state_e;

  state_e           state_q, state_d;
  logic [31:0]      crc_q, crc_d;
  logic [7:0]       shreg_q, shreg_d;
  logic [2:0]       bit_cnt_q, bit_cnt_d;
  logic [CNT_W-1:0] byte_cnt_q, byte_cnt_d;

  logic last_bit;
  logic fb;

  assign last_bit = (state_q == SHIFT) && (bit_cnt_q == 3'd7);
  assign fb       = crc_q[0] ^ shreg_q[0];

  // Pop only when the shifter is free or is consuming its final bit this edge.
  assign fifo_done = rst_n & ~init & ~fifo_empty & ((state_q == IDLE) | last_bit);

  assign crc_out    = ~crc_q;
  assign byte_count = byte_cnt_q;
  assign busy       = (state_q == SHIFT);
  assign idle       = (state_q == IDLE) && fifo_empty;

  always_comb begin
    // NOTE: every next-state signal takes its hold value first so no path leaves it unassigned (no latches).
    state_d    = state_q;
    crc_d      = crc_q;
    shreg_d    = shreg_q;
    bit_cnt_d  = bit_cnt_q;
    byte_cnt_d = byte_cnt_q;

    if (init) begin
      state_d    = IDLE;
      crc_d      = 32'hFFFF_FFFF;
      byte_cnt_d = '0;
    end else begin
      if (state_q == SHIFT) begin
        crc_d     = (crc_q >> 1) ^ (fb ? POLY : 32'h0);
        shreg_d   = shreg_q >> 1;
        bit_cnt_d = bit_cnt_q + 3'd1;
        if (last_bit) begin
          byte_cnt_d = byte_cnt_q + CNT_W'(1);
          state_d    = IDLE;
        end
      end
      // A pop on the last bit overrides the return to IDLE and reloads the shifter.
      if (fifo_done) begin
        shreg_d   = fifo_dout;
        bit_cnt_d = 3'd0;
        state_d   = SHIFT;
      end
    end
  end

  // NOTE: reset is synchronous here, so rst_n is tested inside the clocked branch, not in the sensitivity list.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      crc_q      <= 32'hFFFF_FFFF;
      shreg_q    <= 8'h00;
      bit_cnt_q  <= 3'd0;
      byte_cnt_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the same pre-edge values.
      state_q    <= state_d;
      crc_q      <= crc_d;
      shreg_q    <= shreg_d;
      bit_cnt_q  <= bit_cnt_d;
      byte_cnt_q <= byte_cnt_d;
    end
  end

endmodule

// File: tb/tb_crc32_fifo_reader.sv
// Self-checking bench: a queue-based FIFO feeds the DUT and a byte-level timing/CRC model
// predicts every output each cycle; directed literals pin the known CRC-32 results.
module tb_crc32_fifo_reader;

  localparam logic [31:0] POLY = 32'hEDB88320;

  logic        clk;
  logic        rst_n;
  logic        init;
  logic [7:0]  fifo_dout;
  logic        fifo_empty;
  logic        fifo_done;
  logic [31:0] crc_out;
  logic [15:0] byte_count;
  logic        busy;
  logic        idle;

  crc32_fifo_reader #(.POLY(POLY), .CNT_W(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .init      (init),
    .fifo_dout (fifo_dout),
    .fifo_empty(fifo_empty),
    .fifo_done (fifo_done),
    .crc_out   (crc_out),
    .byte_count(byte_count),
    .busy      (busy),
    .idle      (idle)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference CRC-32 byte update, written the textbook byte-wise way.
  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c ^ {24'h0, b};
    for (int i = 0; i < 8; i++) r = r[0] ? ((r >> 1) ^ POLY) : (r >> 1);
    return r;
  endfunction

  function automatic logic [31:0] crc_of(input string s);
    logic [31:0] r;
    r = 32'hFFFF_FFFF;
    for (int i = 0; i < s.len(); i++) r = crc_byte(r, s[i]);
    return ~r;
  endfunction

  // Behavioural FWFT FIFO (unbounded queue; the stimulus keeps it within 8 entries).
  logic [7:0] q[$];
  bit         pop_pending = 1'b0;

  task automatic upd_fifo();
    fifo_empty = (q.size() == 0);
    fifo_dout  = (q.size() == 0) ? 8'h00 : q[0];
  endtask

  always @(posedge clk) begin
    if (pop_pending) begin
      pop_pending = 1'b0;
      #1;
      if (q.size() != 0) void'(q.pop_front());
      upd_fifo();
    end
  end

  // Model state: m_left = bit-steps still owed for the current byte (0 = no byte in flight).
  logic [31:0] m_crc  = 32'hFFFF_FFFF;
  logic [15:0] m_cnt  = 16'd0;
  int          m_left = 0;
  logic [7:0]  m_cur  = 8'h00;
  int          pop_cnt = 0;
  int          busy_cnt = 0;

  // Single compare process: samples 1 time unit before each rising edge, then advances the model.
  always @(negedge clk) begin
    bit e_done;
    #4;
    e_done = rst_n && !init && (q.size() != 0) && (m_left == 0 || m_left == 1);
    check("fifo_done", fifo_done, e_done);
    check("busy", busy, m_left > 0);
    check("idle", idle, (m_left == 0) && (q.size() == 0));
    check("byte_count", byte_count, m_cnt);
    if (m_left == 0 || m_left == 8) check("crc_out", crc_out, ~m_crc);
    if (fifo_done) pop_cnt++;
    if (busy) busy_cnt++;
    pop_pending = fifo_done;

    if (!rst_n || init) begin
      m_crc  = 32'hFFFF_FFFF;
      m_cnt  = 16'd0;
      m_left = 0;
    end else begin
      if (m_left > 0) begin
        m_left--;
        if (m_left == 0) begin
          m_crc = crc_byte(m_crc, m_cur);
          m_cnt++;
        end
      end
      if (e_done) begin
        m_cur  = q[0];
        m_left = 8;
      end
    end
  end

  task automatic push(input logic [7:0] b);
    int guard;
    guard = 0;
    @(negedge clk);
    while (q.size() >= 8 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    q.push_back(b);
    upd_fifo();
  endtask

  task automatic push_str(input string s);
    for (int i = 0; i < s.len(); i++) push(s[i]);
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(idle === 1'b1 && m_left == 0) && n < budget);
    check({name, "_timeout"}, (n >= budget), 1'b0);
  endtask

  task automatic wait_model(input string name, input int cnt, input int left, input int budget);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(m_cnt == cnt && m_left == left) && n < budget);
    check({name, "_timeout"}, (n >= budget), 1'b0);
  endtask

  task automatic pulse_init();
    @(negedge clk);
    init = 1'b1;
    @(negedge clk);
    init = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required finish before 200000");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    init  = 1'b0;
    upd_fifo();

    // Pin the reference model against published CRC-32 check values.
    check("model_123456789", crc_of("123456789"), 32'hCBF43926);
    check("model_a", crc_of("a"), 32'hE8B7BE43);

    repeat (2) @(negedge clk);
    check("rst_crc_out", crc_out, 32'h0000_0000);
    check("rst_byte_count", byte_count, 16'd0);
    check("rst_busy", busy, 1'b0);
    check("rst_idle", idle, 1'b1);
    check("rst_fifo_done", fifo_done, 1'b0);
    rst_n = 1'b1;

    // Check string, one write per cycle.
    @(negedge clk);
    pop_cnt  = 0;
    busy_cnt = 0;
    push_str("123456789");
    wait_idle("str9", 200);
    check("str9_crc", crc_out, 32'hCBF43926);
    check("str9_count", byte_count, 16'd9);
    check("str9_pops", pop_cnt, 9);
    check("str9_busy_cycles", busy_cnt, 72);

    pulse_init();
    check("init_crc", crc_out, 32'h0000_0000);
    push(8'h61);
    wait_idle("byte_a", 50);
    check("a_crc", crc_out, 32'hE8B7BE43);
    check("a_count", byte_count, 16'd1);

    pulse_init();
    push(8'h00);
    wait_idle("byte_00", 50);
    check("zero_crc", crc_out, 32'hD202EF8D);
    check("zero_count", byte_count, 16'd1);
    pulse_init();
    check("init2_crc", crc_out, 32'h0000_0000);
    check("init2_count", byte_count, 16'd0);

    // Abort byte '4' at bit_cnt 3; "5678" stays queued and is folded first.
    push_str("12345678");
    wait_model("abort", 3, 5, 200);
    @(negedge clk);
    init = 1'b1;
    @(negedge clk);
    init = 1'b0;
    check("abort_count", byte_count, 16'd0);
    check("abort_queue", q.size(), 4);
    push_str("123456789");
    wait_idle("abort_tail", 400);
    check("abort_tail_count", byte_count, 16'd13);
    check("abort_tail_crc", crc_out, crc_of("5678123456789"));
    pulse_init();
    push_str("123456789");
    wait_idle("str9b", 200);
    check("str9b_crc", crc_out, 32'hCBF43926);

    // Reset mid-byte with data still queued.
    pulse_init();
    push_str("123");
    wait_model("rst_mid", 0, 4, 100);
    @(negedge clk);
    rst_n = 1'b0;
    #4;
    check("rst_mid_fifo_done", fifo_done, 1'b0);
    @(negedge clk);
    check("rst_mid_crc", crc_out, 32'h0000_0000);
    check("rst_mid_count", byte_count, 16'd0);
    check("rst_mid_busy", busy, 1'b0);
    check("rst_mid_fifo_done2", fifo_done, 1'b0);
    rst_n = 1'b1;
    wait_idle("rst_mid_tail", 100);
    check("rst_mid_tail_count", byte_count, 16'd2);
    check("rst_mid_tail_crc", crc_out, crc_of("23"));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
